// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state type, default baud divisor.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz / 38.4 kbaud, also used by the transmitter
    localparam int DEFAULT_CLK_DIV = 1302;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        RX_ERROR
    } rx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO; head word is presented combinationally on dout.
module uart_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with per-word parity flag, sticky frame/overrun flags and FWFT buffer.
// state | meaning: IDLE wait start edge; START mid-start check; DATA shift bits; PAR parity; STOP stop bits; ERROR wait line high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd_in,
    input  logic                        read,
    input  logic                        err_clr,
    output logic [DATA_BITS-1:0]        data_out,
    output logic                        data_perr,
    output logic                        new_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] TICK     = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF     = CW'(CLK_DIV / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 rxs_meta;
    logic                 rxs;
    logic [CW-1:0]        cntr;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 tick;
    logic                 push;
    logic                 frame_set;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 par_xor;

    assign tick    = (cntr == TICK);
    assign par_xor = (^shreg) ^ rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxs_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxs_meta <= rxd_in;
            rxs      <= rxs_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        frame_set  = 1'b0;
        case (state)
            RX_IDLE:  if (!rxs) state_next = RX_START;
            RX_START: if (cntr == HALF) state_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tick && bit_idx == LAST_BIT) begin
                    state_next = (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
                end
            end
            RX_PAR:   if (tick) state_next = RX_STOP;
            RX_STOP: begin
                if (tick) begin
                    if (!rxs) begin
                        frame_set  = 1'b1;
                        state_next = RX_ERROR;
                    end else if (stop_idx == LAST_STP) begin
                        push       = 1'b1;
                        state_next = RX_IDLE;
                    end
                end
            end
            RX_ERROR: if (rxs) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntr     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
        end else begin
            if (state != state_next || state == RX_IDLE || state == RX_ERROR || tick) begin
                cntr <= '0;
            end else begin
                cntr <= cntr + CW'(1);
            end

            if (state == RX_IDLE) begin
                bit_idx <= '0;
                perr    <= 1'b0;
            end else if (state == RX_DATA && tick) begin
                shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                bit_idx <= (bit_idx == LAST_BIT) ? 3'd0 : bit_idx + 3'd1;
            end

            if (state == RX_PAR && tick) begin
                perr <= (PARITY == PAR_ODD) ? ~par_xor : par_xor;
            end

            if (state != RX_STOP) begin
                stop_idx <= 1'b0;
            end else if (tick) begin
                stop_idx <= stop_idx + 1'b1;
            end
        end
    end

    assign pop      = read && !empty;
    assign new_data = !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (push && full && !pop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({perr, shreg}),
        .dout  ({data_perr, data_out}),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );
endmodule
